// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: sequencer state encoding and the
// ACK/NACK levels seen on SDA. Used by the sequencer, the SDA datapath and
// the register block.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        STOP
    } i2c_state_e;

    // SDA level during an acknowledge slot
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_counter.sv
// Loadable down-counter used as the I2C bit index (MSB first).
// Ports:
//   clk_i       core clock
//   rst_ni      asynchronous active-low reset (count returns to 0)
//   load_i      load load_val_i (takes priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one; holds at zero
//   cnt_o       current count
//   tc_o        terminal count (cnt_o == 0)
module i2c_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/i2c_master_fsm.sv
// Bit-level sequencer for the I2C master datapath. One I2C bit per core
// clock: START, address + R/W, address ACK, data bytes with ACK/NACK, STOP.
// All outputs are registered and line up with the state they belong to.
//
// Optional feature (macro I2C_MASTER_REPEATED_START_EN): adds restart_i; at
// the end of a data byte's ACK phase a transfer that would otherwise stop
// issues a repeated START instead, re-latching rw_i.
//
// Ports:
//   i2c_core_clk_i     core clock
//   i2c_core_rst_ni    asynchronous active-low reset (aborts, no STOP)
//   enable_i           start/continue transfers
//   rw_i               direction latched at START (0 write, 1 read)
//   sda_i              SDA input, sampled in slave ACK slots
//   tx_empty_i         TX FIFO empty
//   rx_full_i          RX FIFO full
//   restart_i          repeated-start request (macro only)
//   sda_low_o          force SDA low
//   write_addr_en_o    datapath shifts address/RW bit bit_idx_o
//   write_data_en_o    datapath shifts data bit bit_idx_o
//   receive_data_en_o  datapath samples SDA into bit bit_idx_o
//   bit_idx_o          current bit index
//   scl_en_o           SCL toggles while high
//   tx_rd_o            TX FIFO pop
//   rx_wr_o            RX FIFO push
//   busy_o             sequencer not idle
//   nack_o             sticky slave NACK, cleared by START
module i2c_master_fsm
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 7,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             i2c_core_clk_i,
    input  logic             i2c_core_rst_ni,
    input  logic             enable_i,
    input  logic             rw_i,
    input  logic             sda_i,
    input  logic             tx_empty_i,
    input  logic             rx_full_i,
`ifdef I2C_MASTER_REPEATED_START_EN
    input  logic             restart_i,
`endif
    output logic             sda_low_o,
    output logic             write_addr_en_o,
    output logic             write_data_en_o,
    output logic             receive_data_en_o,
    output logic [CNT_W-1:0] bit_idx_o,
    output logic             scl_en_o,
    output logic             tx_rd_o,
    output logic             rx_wr_o,
    output logic             busy_o,
    output logic             nack_o
);

    i2c_state_e state_q, state_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic       stop_ph_q, stop_ph_d;
    logic       sda_low_q, sda_low_d;
    logic       wa_q, wa_d;
    logic       wd_q, wd_d;
    logic       rd_q, rd_d;
    logic       scl_q, scl_d;
    logic       tx_rd_q, tx_rd_d;
    logic       rx_wr_q, rx_wr_d;
    logic       busy_q, busy_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_tc;

    // Where a transfer goes when it is not continuing with another byte.
    i2c_state_e end_state;
    always_comb begin
        end_state = STOP;
`ifdef I2C_MASTER_REPEATED_START_EN
        if (restart_i) begin
            end_state = START;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        nack_d    = nack_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        tx_rd_d   = 1'b0;
        rx_wr_d   = 1'b0;
        sda_low_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_i && (rw_i || !tx_empty_i)) begin
                    state_d = START;
                end
            end
            START: state_d = ADDR;
            ADDR: begin
                if (cnt_tc) state_d = ADDR_ACK;
                else        cnt_dec = 1'b1;
            end
            ADDR_ACK: begin
                if (sda_i == I2C_NACK) begin
                    nack_d  = 1'b1;
                    state_d = STOP;
                end else begin
                    state_d  = rw_q ? RDATA : WDATA;
                    tx_rd_d  = !rw_q;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DATA_SIZE - 1);
                end
            end
            WDATA: begin
                if (cnt_tc) state_d = WACK;
                else        cnt_dec = 1'b1;
            end
            WACK: begin
                if (sda_i == I2C_NACK) begin
                    nack_d  = 1'b1;
                    state_d = STOP;
                end else if (!tx_empty_i && enable_i) begin
                    state_d  = WDATA;
                    tx_rd_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DATA_SIZE - 1);
                end else begin
                    state_d = end_state;
                end
            end
            RDATA: begin
                if (cnt_tc) begin
                    state_d = RACK;
                    rx_wr_d = 1'b1;
                    // ACK/NACK is decided on the last bit so the registered
                    // SDA drive is already valid throughout RACK.
                    sda_low_d = enable_i && !rx_full_i;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RACK: begin
                if (sda_low_q) begin
                    state_d  = RDATA;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DATA_SIZE - 1);
                end else begin
                    state_d = end_state;
                end
            end
            STOP: begin
                if (stop_ph_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every entry into START (fresh or repeated) re-latches direction,
        // clears the sticky NACK and points the index at the address MSB.
        if (state_d == START && state_q != START) begin
            rw_d     = rw_i;
            nack_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(ADDR_SIZE);
        end

        stop_ph_d = (state_d == STOP) && (state_q == STOP);
        if ((state_d == START) || ((state_d == STOP) && (state_q != STOP))) begin
            sda_low_d = 1'b1;
        end
        wa_d   = (state_d == ADDR);
        wd_d   = (state_d == WDATA);
        rd_d   = (state_d == RDATA);
        scl_d  = state_d inside {ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK};
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i2c_core_clk_i or negedge i2c_core_rst_ni) begin
        if (!i2c_core_rst_ni) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            nack_q    <= 1'b0;
            stop_ph_q <= 1'b0;
            sda_low_q <= 1'b0;
            wa_q      <= 1'b0;
            wd_q      <= 1'b0;
            rd_q      <= 1'b0;
            scl_q     <= 1'b0;
            tx_rd_q   <= 1'b0;
            rx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
            stop_ph_q <= stop_ph_d;
            sda_low_q <= sda_low_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
            scl_q     <= scl_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            busy_q    <= busy_d;
        end
    end

    i2c_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk_i      (i2c_core_clk_i),
        .rst_ni     (i2c_core_rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (bit_idx_o),
        .tc_o       (cnt_tc)
    );

    assign sda_low_o         = sda_low_q;
    assign write_addr_en_o   = wa_q;
    assign write_data_en_o   = wd_q;
    assign receive_data_en_o = rd_q;
    assign scl_en_o          = scl_q;
    assign tx_rd_o           = tx_rd_q;
    assign rx_wr_o           = rx_wr_q;
    assign busy_o            = busy_q;
    assign nack_o            = nack_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Self-checking bench for i2c_master_fsm. Frames are described at transfer
// level (phases, bytes, ACK slots) and expanded into per-cycle input and
// expected-output queues; one loop drives and compares every cycle.
module tb_i2c_master_fsm;

    typedef struct packed {
        logic en;
        logic rw;
        logic sda;
        logic txe;
        logic rxf;
        logic rs;
    } in_t;

    typedef struct packed {
        logic       sda_low;
        logic       wa;
        logic       wd;
        logic       rd;
        logic [3:0] idx;
        logic       scl;
        logic       txrd;
        logic       rxwr;
        logic       busy;
        logic       nack;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, rw, sda, tx_empty, rx_full;
`ifdef I2C_MASTER_REPEATED_START_EN
    logic       restart;
`endif
    logic       sda_low, wa, wd, rd, scl, txrd, rxwr, busy, nack;
    logic [3:0] idx;

    i2c_master_fsm #(
        .DATA_SIZE (8),
        .ADDR_SIZE (7),
        .CNT_W     (4)
    ) dut (
        .i2c_core_clk_i    (clk),
        .i2c_core_rst_ni   (rst_n),
        .enable_i          (enable),
        .rw_i              (rw),
        .sda_i             (sda),
        .tx_empty_i        (tx_empty),
        .rx_full_i         (rx_full),
`ifdef I2C_MASTER_REPEATED_START_EN
        .restart_i         (restart),
`endif
        .sda_low_o         (sda_low),
        .write_addr_en_o   (wa),
        .write_data_en_o   (wd),
        .receive_data_en_o (rd),
        .bit_idx_o         (idx),
        .scl_en_o          (scl),
        .tx_rd_o           (txrd),
        .rx_wr_o           (rxwr),
        .busy_o            (busy),
        .nack_o            (nack)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    in_t  in_q[$];
    out_t out_q[$];
    in_t  cur;
    logic m_nack = 1'b0;

    // Observations of the last run, pinned against hand-computed literals.
    int obs_txrd, obs_rxwr, obs_busy, obs_sdalow_n, obs_stop_cyc;
    int txrd_cyc[$];

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.sda_low = sda_low; o.wa = wa; o.wd = wd; o.rd = rd; o.idx = idx;
        o.scl = scl; o.txrd = txrd; o.rxwr = rxwr; o.busy = busy; o.nack = nack;
        return o;
    endfunction

    function automatic out_t mk(input logic sl, input logic a, input logic w, input logic r,
                                input logic [3:0] i, input logic s, input logic t,
                                input logic x, input logic b);
        out_t o;
        o.sda_low = sl; o.wa = a; o.wd = w; o.rd = r; o.idx = i;
        o.scl = s; o.txrd = t; o.rxwr = x; o.busy = b; o.nack = m_nack;
        return o;
    endfunction

    task automatic drive(input in_t c);
        enable   = c.en;
        rw       = c.rw;
        sda      = c.sda;
        tx_empty = c.txe;
        rx_full  = c.rxf;
`ifdef I2C_MASTER_REPEATED_START_EN
        restart  = c.rs;
`endif
    endtask

    task automatic push(input in_t c, input out_t o);
        in_q.push_back(c);
        out_q.push_back(o);
    endtask

    // ---- transfer-level model ------------------------------------------
    task automatic idle_n(input int n);
        cur.en = 1'b0;
        cur.rs = 1'b0;
        for (int i = 0; i < n; i++) push(cur, mk(0,0,0,0,4'd0,0,0,0,0));
    endtask

    task automatic start_addr();
        m_nack = 1'b0;
        push(cur, mk(1,0,0,0,4'd7,0,0,0,1));
        for (int k = 7; k >= 0; k--) push(cur, mk(0,1,0,0,4'(k),1,0,0,1));
    endtask

    task automatic addr_ack(input logic slave_nack);
        in_t c;
        c = cur;
        c.sda = slave_nack;
        push(c, mk(0,0,0,0,4'd0,1,0,0,1));
    endtask

    task automatic do_stop();
        cur.en = 1'b0;
        cur.rs = 1'b0;
        push(cur, mk(1,0,0,0,4'd0,0,0,0,1));
        push(cur, mk(0,0,0,0,4'd0,0,0,0,1));
    endtask

    // Read n bytes; enable is dropped as the last byte begins, so the
    // master ACKs every byte but the last.
    task automatic read_bytes(input int n);
        logic ack;
        for (int b = 0; b < n; b++) begin
            for (int k = 7; k >= 0; k--) begin
                if (b == n - 1 && k == 7) cur.en = 1'b0;
                push(cur, mk(0,0,0,1,4'(k),1,0,0,1));
            end
            ack = cur.en && !cur.rxf;
            push(cur, mk(ack,0,0,0,4'd0,1,0,1,1));
        end
        do_stop();
    endtask

    task automatic frame_write(input int n, input logic anack, input logic rxf, input logic rstart);
        in_t c;
        cur = '0;
        cur.en = 1'b1; cur.rw = 1'b0; cur.txe = 1'b0; cur.rxf = rxf; cur.sda = 1'b1;
        push(cur, mk(0,0,0,0,4'd0,0,0,0,0));
        start_addr();
        addr_ack(anack);
        if (anack) begin
            m_nack = 1'b1;
            do_stop();
            return;
        end
        for (int b = 0; b < n; b++) begin
            for (int k = 7; k >= 0; k--) push(cur, mk(0,0,1,0,4'(k),1,(k == 7),0,1));
            c = cur;
            c.sda = 1'b0;
            if (b == n - 1) begin
                c.txe = 1'b1;
                if (rstart) begin
                    c.rs = 1'b1;
                    c.rw = 1'b1;
                end
            end
            push(c, mk(0,0,0,0,4'd0,1,0,0,1));
        end
        if (rstart) begin
            cur.rw = 1'b1; cur.txe = 1'b1;
            start_addr();
            addr_ack(1'b0);
            read_bytes(1);
        end else begin
            do_stop();
        end
    endtask

    task automatic frame_read(input int n);
        cur = '0;
        cur.en = 1'b1; cur.rw = 1'b1; cur.txe = 1'b1; cur.sda = 1'b1;
        push(cur, mk(0,0,0,0,4'd0,0,0,0,0));
        start_addr();
        addr_ack(1'b0);
        read_bytes(n);
    endtask

    // ---- per-cycle drive and compare -------------------------------------
    task automatic run_queue(input int max);
        out_t act, exp;
        in_t  c;
        obs_txrd = 0; obs_rxwr = 0; obs_busy = 0; obs_sdalow_n = 0; obs_stop_cyc = 0;
        txrd_cyc.delete();
        for (int i = 1; i <= max && out_q.size() > 0; i++) begin
            @(negedge clk);
            act = dut_out();
            exp = out_q.pop_front();
            c   = in_q.pop_front();
            check_out($sformatf("cycle %0d", i), act, exp);
            if (act.txrd) begin
                obs_txrd++;
                txrd_cyc.push_back(i);
            end
            if (act.rxwr) obs_rxwr++;
            if (act.busy) obs_busy++;
            if (act.sda_low) begin
                obs_sdalow_n++;
                if (obs_sdalow_n == 2) obs_stop_cyc = i;
            end
            drive(c);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        cur = '0;
        drive(cur);
        #1 rst_n = 1'b0;
        #3 check_out("reset state", dut_out(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single-byte write, slave ACKs
        frame_write(1, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        run_queue(1000);
        check_int("t1 tx_rd pulses", obs_txrd, 1);
        check_int("t1 STOP cycle", obs_stop_cyc, 21);
        check_int("t1 busy cycles", obs_busy, 21);
        check_int("t1 nack", int'(nack), 0);

        // 2: address NACK
        frame_write(1, 1'b1, 1'b0, 1'b0);
        idle_n(2);
        run_queue(1000);
        check_int("t2 tx_rd pulses", obs_txrd, 0);
        check_int("t2 rx_wr pulses", obs_rxwr, 0);
        check_int("t2 nack", int'(nack), 1);

        // 3: two-byte read, enable dropped during byte 2
        frame_read(2);
        idle_n(2);
        run_queue(1000);
        check_int("t3 rx_wr pulses", obs_rxwr, 2);
        check_int("t3 tx_rd pulses", obs_txrd, 0);
        check_int("t3 nack", int'(nack), 0);

        // 4: three queued bytes, RX FIFO full is irrelevant to a write
        frame_write(3, 1'b0, 1'b1, 1'b0);
        idle_n(2);
        run_queue(1000);
        check_int("t4 tx_rd pulses", obs_txrd, 3);
        if (txrd_cyc.size() == 3) begin
            check_int("t4 spacing 1", txrd_cyc[1] - txrd_cyc[0], 9);
            check_int("t4 spacing 2", txrd_cyc[2] - txrd_cyc[1], 9);
        end
        check_int("t4 busy after", int'(busy), 0);

        // 5: asynchronous reset in the middle of WDATA, then a normal write
        frame_write(1, 1'b0, 1'b0, 1'b0);
        run_queue(15);
        in_q.delete();
        out_q.delete();
        check_int("t5 in WDATA", int'(wd), 1);
        #2 rst_n = 1'b0;
        cur = '0;
        drive(cur);
        #1 check_out("t5 async reset", dut_out(), '0);
        m_nack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_write(1, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        run_queue(1000);
        check_int("t5 tx_rd pulses", obs_txrd, 1);
        check_int("t5 STOP cycle", obs_stop_cyc, 21);

`ifdef I2C_MASTER_REPEATED_START_EN
        // 6: repeated START after a write byte, then a one-byte read
        frame_write(1, 1'b0, 1'b0, 1'b1);
        idle_n(2);
        run_queue(1000);
        check_int("t6 tx_rd pulses", obs_txrd, 1);
        check_int("t6 rx_wr pulses", obs_rxwr, 1);
        check_int("t6 START as 2nd SDA-low", obs_stop_cyc, 21);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
